// File: rtl/ym3438_phase_seq_if.sv
// Bus between the OPN2 phase sequencer and its consumers/debugger.
// The master side drives hold/step_req; the slave side (the sequencer) drives the enables and slot state.
interface ym3438_phase_seq_if #(
    parameter int DIV   = 6,
    parameter int SLOTS = 24
) ();
    logic                     hold;
    logic                     step_req;
    logic                     step_ack;
    logic                     c1;
    logic                     c2;
    logic [$clog2(DIV)-1:0]   presc;
    logic [$clog2(SLOTS)-1:0] slot;
    logic                     slot_sync;
    logic                     frame_tick;

    modport master (
        output hold, step_req,
        input  step_ack, c1, c2, presc, slot, slot_sync, frame_tick
    );

    modport slave (
        input  hold, step_req,
        output step_ack, c1, c2, presc, slot, slot_sync, frame_tick
    );
endinterface

// File: rtl/ym3438_phase_seq.sv
// Two-phase c1/c2 enable sequencer and operator slot counter for the OPN2 core.
// Define YM3438_DBG_STEP_EN to build the hold/single-step debug controller; otherwise the core free-runs.
module ym3438_phase_seq #(
    parameter int DIV   = 6,
    parameter int SLOTS = 24
) (
    input  logic              MCLK,
    input  logic              IC,
    ym3438_phase_seq_if.slave bus
);
    localparam int PW = $clog2(DIV);
    localparam int SW = $clog2(SLOTS);
    localparam logic [PW-1:0] P_LAST = PW'(DIV - 1);
    localparam logic [PW-1:0] P_HALF = PW'(DIV / 2);
    localparam logic [SW-1:0] S_LAST = SW'(SLOTS - 1);

    typedef enum logic [2:0] {
        INIT,
        RUN,
        HELD,
        STEP,
        ACK
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [PW-1:0] p;
    logic [SW-1:0] slot;
    logic          en;
    logic          c1;
    logic          c2;
    logic          slot_sync;

    // Every output is a pure decode of registered state, so c1/c2 are glitch-free enables.
    assign en        = (state == RUN) || (state == STEP);
    assign c1        = en && (p == '0);
    assign c2        = en && (p == P_HALF);
    assign slot_sync = (slot == S_LAST);

    always_ff @(posedge MCLK) begin
        if (!IC) begin
            state <= INIT;
            p     <= '0;
            slot  <= '0;
        end else begin
            state <= state_next;
            if (en) begin
                p <= (p == P_LAST) ? '0 : p + 1'b1;
            end
            if (c2) begin
                slot <= slot_sync ? '0 : slot + 1'b1;
            end
        end
    end

`ifdef YM3438_DBG_STEP_EN
    logic cycle_end;

    // Freezing only on the last prescaler phase keeps every internal cycle whole.
    assign cycle_end = en && (p == P_LAST);

    always_comb begin
        state_next = state;
        case (state)
            INIT:    state_next = bus.hold ? HELD : RUN;
            RUN:     if (cycle_end && bus.hold) state_next = HELD;
            HELD: begin
                if (!bus.hold) begin
                    state_next = RUN;
                end else if (bus.step_req) begin
                    state_next = STEP;
                end
            end
            STEP:    if (cycle_end) state_next = ACK;
            ACK:     if (!bus.step_req) state_next = HELD;
            default: state_next = INIT;
        endcase
    end

    assign bus.step_ack = (state == ACK);
`else
    logic unused_dbg;

    assign unused_dbg = bus.hold ^ bus.step_req;

    always_comb begin
        state_next = state;
        case (state)
            INIT:    state_next = RUN;
            RUN:     state_next = RUN;
            default: state_next = INIT;
        endcase
    end

    assign bus.step_ack = 1'b0;
`endif

    assign bus.c1         = c1;
    assign bus.c2         = c2;
    assign bus.presc      = p;
    assign bus.slot       = slot;
    assign bus.slot_sync  = slot_sync;
    assign bus.frame_tick = c2 && slot_sync;
endmodule

// File: tb/tb_ym3438_phase_seq.sv
// Self-checking bench for ym3438_phase_seq: directed scenarios plus randomized hold/step/reset traffic
// compared against an arithmetic model (slot/prescaler derived from the count of enabled periods).
module tb_ym3438_phase_seq;
    localparam int DIV   = 6;
    localparam int SLOTS = 24;
    localparam int PW    = $clog2(DIV);
    localparam int SW    = $clog2(SLOTS);
    localparam int OW    = 5 + SW + PW;

    localparam int M_INIT = 0;
    localparam int M_RUN  = 1;
    localparam int M_HELD = 2;
    localparam int M_STEP = 3;
    localparam int M_ACK  = 4;

    logic MCLK = 1'b0;
    logic IC   = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    int m_mode = M_INIT;
    int m_n    = 0;

    ym3438_phase_seq_if #(.DIV(DIV), .SLOTS(SLOTS)) bus ();

    ym3438_phase_seq #(.DIV(DIV), .SLOTS(SLOTS)) dut (
        .MCLK (MCLK),
        .IC   (IC),
        .bus  (bus)
    );

    always #5 MCLK = ~MCLK;

    // Model: m_n counts enabled MCLK periods since reset; phase, slot and enables follow arithmetically.
    function automatic void model_edge();
        bit en_b;
        bit last;
        if (!IC) begin
            m_mode = M_INIT;
            m_n    = 0;
            return;
        end
        en_b = (m_mode == M_RUN) || (m_mode == M_STEP);
        last = en_b && ((m_n % DIV) == DIV - 1);
`ifdef YM3438_DBG_STEP_EN
        case (m_mode)
            M_INIT: m_mode = bus.hold ? M_HELD : M_RUN;
            M_RUN:  if (last && bus.hold) m_mode = M_HELD;
            M_HELD: begin
                if (!bus.hold) m_mode = M_RUN;
                else if (bus.step_req) m_mode = M_STEP;
            end
            M_STEP: if (last) m_mode = M_ACK;
            M_ACK:  if (!bus.step_req) m_mode = M_HELD;
            default: m_mode = M_INIT;
        endcase
`else
        m_mode = M_RUN;
`endif
        if (en_b) m_n++;
    endfunction

    function automatic logic [OW-1:0] model_out();
        bit en;
        bit e1;
        bit e2;
        bit sync;
        int ph;
        int sl;
        en   = (m_mode == M_RUN) || (m_mode == M_STEP);
        ph   = m_n % DIV;
        sl   = ((m_n + DIV / 2 - 1) / DIV) % SLOTS;
        e1   = en && (ph == 0);
        e2   = en && (ph == DIV / 2);
        sync = (sl == SLOTS - 1);
        return {m_mode == M_ACK, e1, e2, e2 && sync, sync, SW'(sl), PW'(ph)};
    endfunction

    function automatic logic [OW-1:0] dut_vec();
        return {bus.step_ack, bus.c1, bus.c2, bus.frame_tick, bus.slot_sync, bus.slot, bus.presc};
    endfunction

    task automatic tick();
        model_edge();
        @(posedge MCLK);
        #1;
    endtask

    task automatic test_reset();
        logic [OW-1:0] got, exp;
        IC = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.hold     = 1'($urandom_range(0, 1));
            bus.step_req = 1'($urandom_range(0, 1));
            tick();
            got = dut_vec(); exp = model_out();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("[TB] FAIL reset_model t=%0t got=%h expected=%h", $time, got, exp);
            end
        end
        checks++;
        if ({bus.c1, bus.c2, bus.step_ack, bus.presc, bus.slot} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_zero got c1=%b c2=%b ack=%b presc=%0d slot=%0d expected all 0",
                     bus.c1, bus.c2, bus.step_ack, bus.presc, bus.slot);
        end
    endtask

    task automatic test_cadence();
        logic [OW-1:0] got, exp;
        bit e1, e2;
        int es;
        bus.hold = 1'b0; bus.step_req = 1'b0; IC = 1'b1;
        for (int period = 1; period <= 8; period++) begin
            tick();
            e1 = (period == 1) || (period == 1 + DIV);
            e2 = (period == 1 + DIV / 2);
            es = (period > 1 + DIV / 2) ? 1 : 0;
            checks++;
            if ({bus.c1, bus.c2, bus.slot} !== {e1, e2, SW'(es)}) begin
                failures++;
                $display("[TB] FAIL cadence period=%0d got c1=%b c2=%b slot=%0d expected c1=%b c2=%b slot=%0d",
                         period, bus.c1, bus.c2, bus.slot, e1, e2, es);
            end
            got = dut_vec(); exp = model_out();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("[TB] FAIL cadence_model t=%0t got=%h expected=%h", $time, got, exp);
            end
        end
    endtask

    task automatic test_frame_wrap();
        logic [OW-1:0] got, exp;
        logic [SW-1:0] prev;
        int  ticks_seen = 0;
        bit  saw_last = 1'b0;
        bit  saw_wrap = 1'b0;
        prev = bus.slot;
        for (int i = 0; i < 2 * DIV * SLOTS; i++) begin
            tick();
            got = dut_vec(); exp = model_out();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("[TB] FAIL frame_model t=%0t got=%h expected=%h", $time, got, exp);
            end
            if (bus.frame_tick) ticks_seen++;
            if (bus.slot == SW'(SLOTS - 1) && bus.slot_sync) saw_last = 1'b1;
            if (prev == SW'(SLOTS - 1) && bus.slot == '0) saw_wrap = 1'b1;
            prev = bus.slot;
        end
        checks++;
        if (ticks_seen != 2) begin
            failures++;
            $display("[TB] FAIL frame_tick_count got=%0d expected=2", ticks_seen);
        end
        checks++;
        if (!(saw_last && saw_wrap)) begin
            failures++;
            $display("[TB] FAIL slot_wrap got last=%b wrap=%b expected 1 1", saw_last, saw_wrap);
        end
    endtask

`ifdef YM3438_DBG_STEP_EN
    task automatic test_hold_mid();
        logic [OW-1:0] got, exp;
        logic [SW-1:0] frozen;
        int waited = 0;
        int pulses = 0;
        bit moved  = 1'b0;
        bus.hold = 1'b0; bus.step_req = 1'b0;
        while (bus.presc !== PW'(2) && waited < 2 * DIV) begin
            tick();
            waited++;
        end
        checks++;
        if (bus.presc !== PW'(2)) begin
            failures++;
            $display("[TB] FAIL hold_wait_p2 got presc=%0d expected 2", bus.presc);
        end
        bus.hold = 1'b1;
        frozen = SW'((int'(bus.slot) + 1) % SLOTS);
        tick();
        checks++;
        if ({bus.c2, bus.presc} !== {1'b1, PW'(DIV / 2)}) begin
            failures++;
            $display("[TB] FAIL hold_c2_finish got c2=%b presc=%0d expected c2=1 presc=%0d",
                     bus.c2, bus.presc, DIV / 2);
        end
        for (int i = 0; i < DIV / 2 + 50; i++) begin
            tick();
            got = dut_vec(); exp = model_out();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("[TB] FAIL hold_model t=%0t got=%h expected=%h", $time, got, exp);
            end
            if (i >= DIV / 2) begin
                if (bus.c1 || bus.c2) pulses++;
                if (bus.presc !== '0 || bus.slot !== frozen) moved = 1'b1;
            end
        end
        checks++;
        if (pulses != 0 || moved) begin
            failures++;
            $display("[TB] FAIL hold_frozen got pulses=%0d moved=%b slot=%0d expected pulses=0 moved=0 slot=%0d",
                     pulses, moved, bus.slot, frozen);
        end
    endtask

    task automatic test_step();
        logic [OW-1:0] got, exp;
        logic [SW-1:0] s0;
        int n_c1, n_c2, lat;
        for (int k = 0; k < 3; k++) begin
            s0 = bus.slot; n_c1 = 0; n_c2 = 0; lat = 0;
            bus.step_req = 1'b1;
            while (bus.step_ack !== 1'b1 && lat < 3 * DIV) begin
                if (k == 2 && lat == 3) bus.hold = 1'b0;
                tick();
                lat++;
                if (bus.c1) n_c1++;
                if (bus.c2) n_c2++;
                got = dut_vec(); exp = model_out();
                checks++;
                if (got !== exp) begin
                    failures++;
                    $display("[TB] FAIL step_model t=%0t got=%h expected=%h", $time, got, exp);
                end
            end
            checks++;
            if (lat != DIV + 1 || n_c1 != 1 || n_c2 != 1) begin
                failures++;
                $display("[TB] FAIL step_shape k=%0d got lat=%0d c1=%0d c2=%0d expected lat=%0d c1=1 c2=1",
                         k, lat, n_c1, n_c2, DIV + 1);
            end
            checks++;
            if (bus.slot !== SW'((int'(s0) + 1) % SLOTS)) begin
                failures++;
                $display("[TB] FAIL step_slot k=%0d got=%0d expected=%0d", k, bus.slot, (int'(s0) + 1) % SLOTS);
            end
            for (int i = 0; i < 4; i++) tick();
            checks++;
            if ({bus.step_ack, bus.c1, bus.c2} !== 3'b100) begin
                failures++;
                $display("[TB] FAIL step_ack_hold got ack=%b c1=%b c2=%b expected 1 0 0", bus.step_ack, bus.c1, bus.c2);
            end
            bus.step_req = 1'b0;
            tick();
            checks++;
            if ({bus.step_ack, bus.c1} !== 2'b00) begin
                failures++;
                $display("[TB] FAIL step_ack_fall got ack=%b c1=%b expected 0 0", bus.step_ack, bus.c1);
            end
        end
        tick();
        checks++;
        if (bus.c1 !== 1'b1) begin
            failures++;
            $display("[TB] FAIL step_release_run got c1=%b expected 1", bus.c1);
        end
    endtask

    task automatic test_reset_mid_step();
        int pulses = 0;
        bus.hold = 1'b1; bus.step_req = 1'b0;
        for (int i = 0; i < 2 * DIV; i++) tick();
        bus.step_req = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (bus.presc !== PW'(2)) begin
            failures++;
            $display("[TB] FAIL rst_step_p2 got presc=%0d expected 2", bus.presc);
        end
        IC = 1'b0;
        tick();
        checks++;
        if ({bus.step_ack, bus.c1, bus.c2, bus.slot, bus.presc} !== '0) begin
            failures++;
            $display("[TB] FAIL rst_step_zero got ack=%b c1=%b c2=%b slot=%0d presc=%0d expected all 0",
                     bus.step_ack, bus.c1, bus.c2, bus.slot, bus.presc);
        end
        bus.step_req = 1'b0; IC = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.c1 || bus.c2 || bus.step_ack) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            failures++;
            $display("[TB] FAIL rst_release_held got active_periods=%0d expected 0", pulses);
        end
    endtask
`else
    task automatic test_ignore_debug();
        logic [OW-1:0] got, exp;
        int last_c1 = -1;
        int n_c1    = 0;
        bus.hold = 1'b1; bus.step_req = 1'b1;
        for (int i = 0; i < 10 * DIV; i++) begin
            tick();
            got = dut_vec(); exp = model_out();
            checks++;
            if (got !== exp || bus.step_ack !== 1'b0) begin
                failures++;
                $display("[TB] FAIL ignore_model t=%0t got=%h expected=%h", $time, got, exp);
            end
            if (bus.c1) begin
                if (last_c1 >= 0) begin
                    checks++;
                    if (i - last_c1 != DIV) begin
                        failures++;
                        $display("[TB] FAIL ignore_c1_gap got=%0d expected=%0d", i - last_c1, DIV);
                    end
                end
                last_c1 = i;
                n_c1++;
            end
        end
        checks++;
        if (n_c1 != 10) begin
            failures++;
            $display("[TB] FAIL ignore_c1_count got=%0d expected=10", n_c1);
        end
    endtask
`endif

    task automatic test_random();
        logic [OW-1:0] got, exp;
        IC = 1'b1;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 7) == 0) bus.hold = ~bus.hold;
            if ($urandom_range(0, 3) == 0) bus.step_req = ~bus.step_req;
            IC = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
            tick();
            got = dut_vec(); exp = model_out();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("[TB] FAIL random_model t=%0t got=%h expected=%h", $time, got, exp);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bus.hold     = 1'b0;
        bus.step_req = 1'b0;
        test_reset();
        test_cadence();
        test_frame_wrap();
`ifdef YM3438_DBG_STEP_EN
        test_hold_mid();
        test_step();
        test_reset_mid_step();
`else
        test_ignore_debug();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
